ps2_key_serializer: RTL

- Upstream stage of the next186 system core's keyboard input.
- Converts the 11-bit hps_io ps2_key event word into PS/2 set-2 byte sequences and shifts them out as a device-to-host PS/2 frame on open-drain style clock/data lines.
- Drives the core's PS2 clock/data inputs (wired-AND with the core's outputs at top level).
- Buffers bursts in a small byte FIFO and honours host inhibit (clock held low by the core).

---
 rtl/ps2_pkg.sv | 10 +
 rtl/ps2_byte_fifo.sv | 32 +++
 rtl/ps2_key_serializer.sv | 100 ++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared FSM states, PS/2 prefix bytes and device-to-host frame builder
package ps2_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_HIGH, ST_LOW, ST_GAP, ST_INHIBIT} state_t;
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam int FRAME_BITS = 11;
  function automatic logic [FRAME_BITS-1:0] ps2_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction
endpackage

// File: rtl/ps2_byte_fifo.sv
// ps2_byte_fifo: synchronous byte FIFO with wrap-bit pointers, occupancy count and async reset
module ps2_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr,
  input  logic [7:0]               i_wdata,
  input  logic                     i_rd,
  output logic [7:0]               o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] r_mem [DEPTH];
  logic [AW:0] r_wp, r_rp;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (i_wr && !o_full) r_wp <= r_wp + 1'b1;
      if (i_rd && !o_empty) r_rp <= r_rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (i_wr && !o_full) r_mem[r_wp[AW-1:0]] <= i_wdata;
  assign o_rdata = r_mem[r_rp[AW-1:0]];
  assign o_count = r_wp - r_rp;
  assign o_empty = r_wp == r_rp;
  assign o_full = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
endmodule

// File: rtl/ps2_key_serializer.sv
// ps2_key_serializer: turns hps_io ps2_key toggle events into set-2 bytes shifted out as PS/2 device frames
module ps2_key_serializer
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 1145,
  parameter int GAP        = 2291,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic        ps2_clk_out,
  output logic        ps2_data_out,
  output logic        busy,
  output logic        overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2((CLK_DIV > GAP ? CLK_DIV : GAP) + 1);
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [3:0] r_idx;
  logic [FRAME_BITS-1:0] r_shift;
  logic r_tog, r_armed, r_ovf;
  logic [23:0] r_stg;
  logic [1:0] r_stg_n;
  logic [7:0] w_head, w_b0, w_b1;
  logic [AW:0] w_count;
  logic [AW+1:0] w_free;
  logic [1:0] w_len;
  logic w_empty, w_full, w_pop, w_evt, w_fit, w_div_done, w_gap_done, w_unused;
  ps2_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_sys), .rst(reset),
    .i_wr(r_stg_n != 2'd0), .i_wdata(r_stg[7:0]), .i_rd(w_pop),
    .o_rdata(w_head), .o_count(w_count), .o_empty(w_empty), .o_full(w_full)
  );
  assign w_unused = ^{ps2_data_in, w_full};
  assign w_b0 = ps2_key[8] ? PS2_EXT : (ps2_key[9] ? ps2_key[7:0] : PS2_BREAK);
  assign w_b1 = ps2_key[8] ? (ps2_key[9] ? ps2_key[7:0] : PS2_BREAK) : ps2_key[7:0];
  assign w_len = 2'd1 + {1'b0, ps2_key[8]} + {1'b0, ~ps2_key[9]};
  assign w_evt = r_armed && (ps2_key[10] != r_tog) && (r_stg_n == 2'd0);
  assign w_free = (AW+2)'(FIFO_DEPTH) - {1'b0, w_count} + (AW+2)'(w_pop);
  assign w_fit = w_free >= {{AW{1'b0}}, w_len};
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      r_tog <= 1'b0;
      r_armed <= 1'b0;
      r_ovf <= 1'b0;
      r_stg <= '0;
      r_stg_n <= '0;
    end else begin
      r_armed <= 1'b1;
      if (!r_armed || w_evt) r_tog <= ps2_key[10];
      if (w_evt && w_fit) begin
        r_stg <= {ps2_key[7:0], w_b1, w_b0};
        r_stg_n <= w_len;
      end else if (r_stg_n != 2'd0) begin
        r_stg <= r_stg >> 8;
        r_stg_n <= r_stg_n - 1'b1;
      end
      if (w_evt && !w_fit) r_ovf <= 1'b1;
    end
  assign w_div_done = r_cnt == CW'(CLK_DIV - 1);
  assign w_gap_done = r_cnt == CW'(GAP - 1);
  assign w_pop = (r_state == ST_LOW) && w_div_done && (r_idx == 4'd10);
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) r_state <= ST_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    w_next = (!w_empty && ps2_clk_in) ? ST_LOAD : ST_IDLE;
      ST_LOAD:    w_next = ST_HIGH;
      ST_HIGH:    w_next = !w_div_done ? ST_HIGH : (!ps2_clk_in && r_idx < 4'd10) ? ST_INHIBIT : ST_LOW;
      ST_LOW:     w_next = !w_div_done ? ST_LOW : (r_idx == 4'd10) ? ST_GAP : ST_HIGH;
      ST_GAP:     w_next = w_gap_done ? ST_IDLE : ST_GAP;
      ST_INHIBIT: w_next = (ps2_clk_in && w_gap_done) ? ST_IDLE : ST_INHIBIT;
      default:    w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_shift <= '1;
    end else begin
      r_cnt <= (w_next != r_state || (r_state == ST_INHIBIT && !ps2_clk_in)) ? '0 : r_cnt + 1'b1;
      if (r_state == ST_LOAD) begin
        r_shift <= ps2_frame(w_head);
        r_idx <= '0;
      end else if (w_div_done && r_state == ST_LOW && r_idx != 4'd10) r_idx <= r_idx + 1'b1;
    end
  always_comb begin
    ps2_clk_out = r_state != ST_LOW;
    ps2_data_out = (r_state == ST_HIGH || r_state == ST_LOW) ? r_shift[r_idx] : 1'b1;
  end
  assign busy = !w_empty || r_state != ST_IDLE;
  assign overflow = r_ovf;
endmodule
